// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder tree and its drain stage.
//   - per-level output widths of the 16 -> 21 bit adder tree
//   - DATA_W datapath width and its saturation limits
//   - state encoding of the tree_sum_narrower drain FSM
package adder_tree_pkg;

  localparam int DATA_W = 16;

  // Each tree level adds one bit of headroom.
  localparam int L1_W = DATA_W + 1;
  localparam int L2_W = DATA_W + 2;
  localparam int L3_W = DATA_W + 3;
  localparam int L4_W = DATA_W + 4;
  localparam int L5_W = DATA_W + 5;

  localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/rescale_sat.sv
// Combinational narrowing of the accumulator to OUT_W bits.
// Order: round half up, arithmetic shift right by SHIFT, optional ReLU, saturate.
// Ports:
//   acc     in  ACC_W  signed accumulator value
//   relu_en in  1      clamp negative results to zero
//   out     out OUT_W  signed narrowed result
//   sat     out 1      result was clipped to the OUT_W range
module rescale_sat #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 5
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] out,
  output logic                    sat
);

  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'((64'sd1 <<< SHIFT) >>> 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] r;

  // ACC_W carries enough headroom that the rounding add cannot wrap.
  assign rnd = acc + RND;

  always_comb begin
    r = rnd >>> SHIFT;
    if (relu_en && (r < 0)) r = '0;
    out = r[OUT_W-1:0];
    sat = 1'b0;
    if (r > MAXV) begin
      out = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (r < MINV) begin
      out = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/tree_sum_narrower.sv
// Drain stage at the adder tree root: accumulates NUM_TILES signed tree sums,
// narrows the total to OUT_W bits and holds it until the consumer takes it.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake, in_sum is the IN_W signed tree sum
//   relu_en             ReLU enable, taken from the final beat of a group
//   out_valid/out_ready output handshake
//   out_data            OUT_W signed narrowed result
//   out_sat             result was clipped to the OUT_W range
module tree_sum_narrower
  import adder_tree_pkg::*;
#(
  parameter int IN_W      = 21,
  parameter int OUT_W     = 16,
  parameter int NUM_TILES = 4,
  parameter int SHIFT     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_sum,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int ACC_W = IN_W + $clog2(NUM_TILES) + 1;
  localparam int CNT_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TILES - 1);

  state_t                    state, state_next;
  logic signed [ACC_W-1:0]   acc, acc_next, sum_ext;
  logic [CNT_W-1:0]          beat_cnt;
  logic                      fire, last;
  logic signed [OUT_W-1:0]   res;
  logic                      res_sat;

  // Both handshake flags decode the state register only, so out_ready never
  // reaches in_ready combinationally and no beat lands on the handshake cycle.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  assign fire     = in_valid && in_ready;
  assign last     = fire && (beat_cnt == LAST);
  assign sum_ext  = {{(ACC_W-IN_W){in_sum[IN_W-1]}}, in_sum};
  assign acc_next = (beat_cnt == '0) ? sum_ext : acc + sum_ext;

  rescale_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_rescale (
    .acc     (acc_next),
    .relu_en (relu_en),
    .out     (res),
    .sat     (res_sat)
  );

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      beat_cnt <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_next;
      if (fire) begin
        acc <= acc_next;
        if (last) begin
          beat_cnt <= '0;
          out_data <= res;
          out_sat  <= res_sat;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule
